// File: rtl/cpu_pkg.sv
// Shared front-end definitions: fetch PC-select encodings, sequencer states and the
// NOP used by datapath flushes.
package cpu_pkg;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_BR    = 2'b01;
    localparam logic [1:0] PCSEL_JALR  = 2'b10;
    localparam logic [1:0] PCSEL_SAVED = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter with increment enable that holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end sequencer: turns EX branch resolution, load-use hazards and the imem
// handshake into IF/ID/EX stall/flush controls and the fetch PC select.
module branch_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        PCSrcE,
    input  logic              imem_ready,
    input  logic              MemReadE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    output logic [1:0]        PCSelF,
    output logic              TgtCapture,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              redirect_pending,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_pend_sel;
    logic       w_redir;
    logic       w_lu;
    logic       w_flush_inc;
    logic       w_stall_inc;

    assign w_redir = (PCSrcE == PCSEL_BR) || (PCSrcE == PCSEL_JALR);
    assign w_lu    = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_pend_sel <= '0;
        end else begin
            r_state <= w_next_state;
            if (TgtCapture) begin
                r_pend_sel <= PCSrcE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:  if (w_redir && !imem_ready) w_next_state = WAIT;
            WAIT: if (imem_ready)             w_next_state = RUN;
            default:                          w_next_state = RUN;
        endcase
    end

    always_comb begin
        PCSelF           = PCSEL_PLUS4;
        TgtCapture       = 1'b0;
        StallF           = 1'b0;
        StallD           = 1'b0;
        FlushD           = 1'b0;
        FlushE           = 1'b0;
        redirect_pending = 1'b0;
        w_flush_inc      = 1'b0;
        w_stall_inc      = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (r_state == WAIT) begin
            redirect_pending = 1'b1;
            FlushD           = 1'b1;
            if (imem_ready) begin
                // A saved select of PC+4 cannot occur; fall back to sequential fetch if it does.
                PCSelF = (r_pend_sel != PCSEL_PLUS4) ? PCSEL_SAVED : PCSEL_PLUS4;
            end else begin
                StallF      = 1'b1;
                w_stall_inc = 1'b1;
            end
        end else if (w_redir && imem_ready) begin
            PCSelF      = PCSrcE;
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_redir) begin
            TgtCapture  = 1'b1;
            StallF      = 1'b1;
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_lu) begin
            // Covers lu with imem not ready too: holding IF/ID wins over flushing it.
            StallF      = 1'b1;
            StallD      = 1'b1;
            FlushE      = 1'b1;
            w_stall_inc = 1'b1;
        end else if (!imem_ready) begin
            StallF      = 1'b1;
            FlushD      = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_flush_inc),
        .o_cnt (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: each directed stimulus cycle queues its hand-computed response;
// a negedge monitor pops and compares it against the DUT outputs.
module tb_branch_redirect_ctrl;

    localparam int CNT_W  = 4;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [1:0]       sel;
        logic             tgt;
        logic             sf;
        logic             sd;
        logic             fd;
        logic             fe;
        logic             pend;
        logic [CNT_W-1:0] fc;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        PCSrcE;
    logic              imem_ready;
    logic              MemReadE;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [1:0]        PCSelF;
    logic              TgtCapture;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              redirect_pending;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    branch_redirect_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PCSrcE           (PCSrcE),
        .imem_ready       (imem_ready),
        .MemReadE         (MemReadE),
        .RdE              (RdE),
        .Rs1D             (Rs1D),
        .Rs2D             (Rs2D),
        .PCSelF           (PCSelF),
        .TgtCapture       (TgtCapture),
        .StallF           (StallF),
        .StallD           (StallD),
        .FlushD           (FlushD),
        .FlushE           (FlushE),
        .redirect_pending (redirect_pending),
        .flush_cnt        (flush_cnt),
        .stall_cnt        (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] sel, input logic tgt, input logic sf,
                                input logic sd, input logic fd, input logic fe,
                                input logic pend, input int fc, input int sc);
        exp_t e;
        e.sel  = sel;
        e.tgt  = tgt;
        e.sf   = sf;
        e.sd   = sd;
        e.fd   = fd;
        e.fe   = fe;
        e.pend = pend;
        e.fc   = CNT_W'(fc);
        e.sc   = CNT_W'(sc);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its response.
    task automatic step(input logic rst, input logic [1:0] pcsrc, input logic rdy,
                        input logic mr, input int rd, input int rs1, input int rs2,
                        input exp_t e);
        @(posedge clk);
        #1;
        rst_n      = rst;
        PCSrcE     = pcsrc;
        imem_ready = rdy;
        MemReadE   = mr;
        RdE        = REG_AW'(rd);
        Rs1D       = REG_AW'(rs1);
        Rs2D       = REG_AW'(rs2);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int fc, input int sc);
        step(1'b1, 2'b00, 1'b1, 1'b0, 0, 0, 0, mk(2'b00, 0, 0, 0, 0, 0, 0, fc, sc));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("PCSelF",           int'(PCSelF),           int'(e.sel));
                chk("TgtCapture",       int'(TgtCapture),       int'(e.tgt));
                chk("StallF",           int'(StallF),           int'(e.sf));
                chk("StallD",           int'(StallD),           int'(e.sd));
                chk("FlushD",           int'(FlushD),           int'(e.fd));
                chk("FlushE",           int'(FlushE),           int'(e.fe));
                chk("redirect_pending", int'(redirect_pending), int'(e.pend));
                chk("flush_cnt",        int'(flush_cnt),        int'(e.fc));
                chk("stall_cnt",        int'(stall_cnt),        int'(e.sc));
                cyc++;
            end
        end
    end

    initial begin : stimulus
        rst_n      = 1'b0;
        PCSrcE     = 2'b00;
        imem_ready = 1'b1;
        MemReadE   = 1'b0;
        RdE        = '0;
        Rs1D       = '0;
        Rs2D       = '0;

        // reset state, then first cycle after release
        step(1'b0, 2'b01, 1'b1, 1'b0, 0, 0, 0, mk(2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
        idle(0, 0);

        // redirect with imem ready: zero-latency, stays in RUN
        step(1'b1, 2'b01, 1'b1, 1'b0, 0, 0, 0, mk(2'b01, 0, 0, 0, 1, 1, 0, 0, 0));
        idle(1, 0);

        // JALR redirect while fetch outstanding: capture, wait 3 more cycles, then saved target
        step(1'b1, 2'b10, 1'b0, 1'b0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 1, 0, 1, 0));
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, mk(2'b00, 0, 1, 0, 1, 0, 1, 2, 0));
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, mk(2'b00, 0, 1, 0, 1, 0, 1, 2, 1));
        step(1'b1, 2'b00, 1'b0, 1'b1, 3, 3, 0, mk(2'b00, 0, 1, 0, 1, 0, 1, 2, 2));
        step(1'b1, 2'b00, 1'b1, 1'b0, 0, 0, 0, mk(2'b11, 0, 0, 0, 1, 0, 1, 2, 3));
        idle(2, 3);

        // load-use on Rs2, then RdE = x0 gives no hazard
        step(1'b1, 2'b00, 1'b1, 1'b1, 5, 1, 5, mk(2'b00, 0, 1, 1, 0, 1, 0, 2, 3));
        idle(2, 4);
        step(1'b1, 2'b00, 1'b1, 1'b1, 0, 0, 0, mk(2'b00, 0, 0, 0, 0, 0, 0, 2, 4));

        // load-use together with imem not ready: single stall count, no FlushD
        step(1'b1, 2'b00, 1'b0, 1'b1, 7, 7, 2, mk(2'b00, 0, 1, 1, 0, 1, 0, 2, 4));
        idle(2, 5);

        // plain fetch wait
        step(1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, mk(2'b00, 0, 1, 0, 1, 0, 0, 2, 5));
        idle(2, 6);

        // enter WAIT then assert reset mid-cycle: pending redirect discarded
        step(1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 1, 0, 2, 6));
        step(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, mk(2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
        step(1'b0, 2'b01, 1'b1, 1'b1, 4, 4, 4, mk(2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
        idle(0, 0);
        idle(0, 0);

        // flush counter saturation
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'b01, 1'b1, 1'b0, 0, 0, 0,
                 mk(2'b01, 0, 0, 0, 1, 1, 0, (i > 15) ? 15 : i, 0));
        end
        idle(15, 0);
        step(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 0, mk(2'b10, 0, 0, 0, 1, 1, 0, 15, 0));
        // illegal PCSrcE = 11 behaves as PC+4
        step(1'b1, 2'b11, 1'b1, 1'b0, 0, 0, 0, mk(2'b00, 0, 0, 0, 0, 0, 0, 15, 0));
        idle(15, 0);

        // stall counter saturation
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0,
                 mk(2'b00, 0, 1, 0, 1, 0, 0, 15, (i > 15) ? 15 : i));
        end
        idle(15, 15);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Front-end sequencer for the 5-stage RV32I pipeline. It consumes the EX-stage PC-source decision (00 = PC+4, 01 = branch/JAL target, 10 = JALR target), the load-use operands and the async instruction-memory handshake. It drives the IF/ID/EX stall and flush controls and the fetch PC select. When a branch is taken while a fetch is still outstanding, it holds the redirect pending until that fetch completes, then discards the wrong-path response.

Parameters:
CNT_W, 16, width of the saturating performance counters
REG_AW, 5, register-index width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; asynchronous, active-low
PCSrcE  in  2  EX-stage PC source from branch resolution (00/01/10; 11 is illegal and treated as 00)
imem_ready  in  1  instruction memory returns the fetch issued at the current PC this cycle
MemReadE  in  1  EX instruction is a load
RdE  in  REG_AW  EX destination register
Rs1D  in  REG_AW  ID source register 1
Rs2D  in  REG_AW  ID source register 2
PCSelF  out  2  fetch PC mux: 00 PC+4, 01 EX branch target, 10 EX JALR target, 11 saved redirect register
TgtCapture  out  1  datapath latches the EX target selected by PCSrcE into the saved redirect register
StallF  out  1  hold the PC register
StallD  out  1  hold the IF/ID register
FlushD  out  1  load NOP into IF/ID
FlushE  out  1  load NOP into ID/EX
redirect_pending  out  1  high while in WAIT
flush_cnt  out  CNT_W  count of redirects, saturating
stall_cnt  out  CNT_W  count of load-use plus fetch-wait stall cycles, saturating

Behaviour:
- States: RUN, WAIT. Registered: state, pend_sel, flush_cnt, stall_cnt.
- All other outputs are combinational from state and inputs.
- While rst_n is low: state = RUN, pend_sel = 00, counters = 0, FlushD = FlushE = 1, all other outputs 0.
- Derived signals:
  - redir = (PCSrcE == 01 or 10)
  - lu = MemReadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D)
- RUN priority, highest first:
  1. redir and imem_ready: PCSelF = PCSrcE, FlushD = 1, FlushE = 1, StallF = StallD = 0. flush_cnt += 1. Stay in RUN. Redirect latency is 0 cycles: the target is fetched on the next edge.
  2. redir and not imem_ready: TgtCapture = 1, pend_sel <= PCSrcE, StallF = 1, FlushD = 1, FlushE = 1. flush_cnt += 1. Go to WAIT.
  3. lu: StallF = StallD = 1, FlushE = 1. stall_cnt += 1. Bubble for exactly one cycle per hazard instance.
  4. not imem_ready: StallF = 1, FlushD = 1. stall_cnt += 1.
  5. Otherwise all controls 0, PCSelF = 00.
- lu and not imem_ready together: StallD has priority over FlushD, so FlushD = 0. stall_cnt increments once, not twice.
- WAIT:
  - StallF = 1, FlushD = 1 every cycle; the outstanding wrong-path response is never written into IF/ID.
  - When imem_ready = 1: StallF = 0, PCSelF = 11 (PC loads the saved target), FlushD = 1, next state RUN.
  - PCSrcE and lu are ignored in WAIT. EX holds a bubble because FlushE was asserted on entry, so a nonzero PCSrcE here is a protocol violation.
  - stall_cnt increments each cycle imem_ready = 0.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- Reset asserted in WAIT: immediate return to RUN, pending redirect discarded.
- Reset released: first cycle behaves per RUN with no pending state.

Decomposition:
- Shared package (cpu_pkg):
  - PCSel encoding constants PCSEL_PLUS4/BR/JALR/SAVED = 00/01/10/11
  - state typedef {RUN, WAIT}
  - NOP encoding, used by datapath flushes
- One natural sub-module: sat_counter (width-parameterised, increment-enable, saturating), instantiated twice.

Test Plan:
1. RUN, imem_ready = 1, PCSrcE = 01 for one cycle -> PCSelF = 01, FlushD = FlushE = 1, StallF = 0, flush_cnt 0 -> 1, state stays RUN.
2. PCSrcE = 10 with imem_ready = 0, then imem_ready low 3 more cycles, then high -> TgtCapture = 1 on the first cycle; redirect_pending high for 4 cycles; StallF = 1 and FlushD = 1 throughout; on the ready cycle PCSelF = 11, StallF = 0; then RUN. stall_cnt = 3, flush_cnt = 1.
3. MemReadE = 1, RdE = 5, Rs2D = 5, imem_ready = 1 -> StallF = StallD = FlushE = 1 for one cycle, FlushD = 0, stall_cnt = 1. Repeat with RdE = 0 -> no stall.
4. lu and imem_ready = 0 in the same cycle -> StallF = StallD = FlushE = 1, FlushD = 0, stall_cnt += 1 only.
5. Enter WAIT, drop rst_n asynchronously mid-cycle -> state RUN, redirect_pending = 0, counters = 0, FlushD = FlushE = 1 while low. After release, imem_ready = 1 and PCSrcE = 00 give PCSelF = 00.
6. CNT_W = 4: 20 consecutive redirects -> flush_cnt reaches 15 and holds. PCSrcE = 11 -> treated as PC+4, no flush.
